gemm_hls_deadlock_persist_monitor: RTL and testbench

Parametrised successor to the per-instance HLS deadlock monitors in the gemm design. Reduces a configurable set of AXI-Stream block signals and sub-instance block signals to one block flag. Unlike the single-cycle monitor, this block:
- requires the condition to persist THRESH consecutive cycles;
- masks channels whose owning instance is idle;
- can latch the result (sticky);
- snapshots which sources caused the detection, for debug readout.

---
 rtl/gemm_hls_deadlock_pkg.sv | 17 +
 rtl/gemm_hls_sat_counter.sv | 23 ++
 rtl/gemm_hls_deadlock_persist_monitor.sv | 136 +++++++++++++
 tb/tb_gemm_hls_deadlock_persist_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_hls_deadlock_pkg.sv
// rtl/gemm_hls_deadlock_pkg.sv - shared types and helpers for the persistent deadlock monitor
package gemm_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    BLOCKED = 2'd2
  } mon_state_e;

  localparam int unsigned DEFAULT_CNT_W = 8;

  // THRESH must be reachable by a CNT_W-bit counter without touching the saturation value.
  function automatic bit thresh_legal(input int unsigned thresh, input int unsigned cnt_w);
    return (thresh >= 1) && (cnt_w >= 1) && (cnt_w < 32) && (thresh < (32'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/gemm_hls_sat_counter.sv
// rtl/gemm_hls_sat_counter.sv - up-counter with sync clear, load-to-one and saturation
module gemm_hls_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Priority: clr, then load1, then inc; holds at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= W'(1);
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gemm_hls_deadlock_persist_monitor.sv
// rtl/gemm_hls_deadlock_persist_monitor.sv - deadlock flag that needs THRESH consecutive blocked cycles
module gemm_hls_deadlock_persist_monitor
  import gemm_hls_deadlock_pkg::*;
#(
  parameter int unsigned          N_AXIS    = 4,
  parameter int unsigned          N_INST    = 1,
  parameter logic [N_AXIS-1:0]    AXIS_MASK = 4'b0110,
  parameter int unsigned          THRESH    = 16,
  parameter int unsigned          CNT_W     = DEFAULT_CNT_W,
  parameter bit                   STICKY    = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_AXIS-1:0]        inst_idle_sigs,
  input  logic [N_INST-1:0]        inst_block_sigs,
  output logic                     block,
  output logic [N_AXIS+N_INST-1:0] block_src,
  output logic [CNT_W-1:0]         block_cycles
);

  generate
    if (!thresh_legal(THRESH, CNT_W)) begin : g_bad_thresh
      $error("gemm_hls_deadlock_persist_monitor: THRESH must be in 1..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic                     wipe;
  logic [N_AXIS-1:0]        axis_hit;
  logic [N_AXIS+N_INST-1:0] src_vec;
  logic                     raw;

  mon_state_e               state_q;
  mon_state_e               state_d;

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic                     cnt_clr;
  logic                     cnt_load1;
  logic                     cnt_inc;
  logic                     enter_blocked;
  logic                     stay_blocked;

  assign wipe = reset | clear;

  // Idle owners and channels outside the mask never contribute, not even to the snapshot.
  assign axis_hit = axis_block_sigs & AXIS_MASK & ~inst_idle_sigs;
  assign src_vec  = {inst_block_sigs, axis_hit};
  assign raw      = |src_vec;
  assign cnt_next = cnt + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw) begin
          if (THRESH == 1) begin
            state_d = BLOCKED;
            cnt_clr = 1'b1;
          end else begin
            state_d   = COUNT;
            cnt_load1 = 1'b1;
          end
        end else begin
          cnt_clr = 1'b1;
        end
      end
      COUNT: begin
        if (!raw) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_next == THRESH_C) begin
          state_d = BLOCKED;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      BLOCKED: begin
        cnt_clr = 1'b1;
        if (!STICKY && !raw) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign enter_blocked = (state_q != BLOCKED) && (state_d == BLOCKED);
  assign stay_blocked  = (state_q == BLOCKED) && (state_d == BLOCKED);

  gemm_hls_sat_counter #(
    .W (CNT_W)
  ) u_persist (
    .clock (clock),
    .clr   (wipe | cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .count (cnt)
  );

  // block_cycles is left untouched on exit so software can read how long the last episode lasted.
  gemm_hls_sat_counter #(
    .W (CNT_W)
  ) u_blocked_cycles (
    .clock (clock),
    .clr   (wipe),
    .load1 (enter_blocked),
    .inc   (stay_blocked),
    .count (block_cycles)
  );

  always_ff @(posedge clock) begin
    if (wipe) begin
      state_q   <= IDLE;
      block     <= 1'b0;
      block_src <= '0;
    end else begin
      state_q <= state_d;
      block   <= (state_d == BLOCKED);
      if (enter_blocked) begin
        block_src <= src_vec;
      end
    end
  end

endmodule

// File: tb/tb_gemm_hls_deadlock_persist_monitor.sv
// tb/tb_gemm_hls_deadlock_persist_monitor.sv - bench for three monitor configurations sharing one stimulus
module tb_gemm_hls_deadlock_persist_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] axis  = '0;
  logic [3:0] idle  = '0;
  logic [0:0] inst  = '0;

  logic       b0, b1, b2;
  logic [4:0] s0, s1, s2;
  logic [7:0] c0, c1;
  logic [3:0] c2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  gemm_hls_deadlock_persist_monitor dut0 (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(inst),
    .block(b0), .block_src(s0), .block_cycles(c0)
  );

  gemm_hls_deadlock_persist_monitor #(.THRESH(1), .STICKY(1'b0)) dut1 (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(inst),
    .block(b1), .block_src(s1), .block_cycles(c1)
  );

  gemm_hls_deadlock_persist_monitor #(.THRESH(2), .CNT_W(4), .STICKY(1'b1)) dut2 (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(inst),
    .block(b2), .block_src(s2), .block_cycles(c2)
  );

  // Reference: run length of consecutive raw cycles, episode flag, snapshot, saturating episode length.
  int m_thresh [3] = '{16, 1, 2};
  int m_sticky [3] = '{1, 0, 1};
  int m_max    [3] = '{255, 255, 15};
  int m_run    [3];
  int m_blk    [3];
  int m_src    [3];
  int m_cyc    [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int src;
    bit raw;
    src = {inst, (axis & 4'b0110 & ~idle)};
    raw = (src != 0);
    for (int i = 0; i < 3; i++) begin
      if (reset || clear) begin
        m_run[i] = 0; m_blk[i] = 0; m_src[i] = 0; m_cyc[i] = 0;
      end else if (m_blk[i] == 0) begin
        if (raw) begin
          m_run[i]++;
          if (m_run[i] == m_thresh[i]) begin
            m_blk[i] = 1; m_src[i] = src; m_cyc[i] = 1; m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end else if (m_sticky[i] == 0 && !raw) begin
        m_blk[i] = 0; m_run[i] = 0;
      end else if (m_cyc[i] < m_max[i]) begin
        m_cyc[i]++;
      end
    end
  endtask

  task automatic compare_model();
    chk("m0_block", int'(b0), m_blk[0]);
    chk("m0_src",   int'(s0), m_src[0]);
    chk("m0_cyc",   int'(c0), m_cyc[0]);
    chk("m1_block", int'(b1), m_blk[1]);
    chk("m1_src",   int'(s1), m_src[1]);
    chk("m1_cyc",   int'(c1), m_cyc[1]);
    chk("m2_block", int'(b2), m_blk[2]);
    chk("m2_src",   int'(s2), m_src[2]);
    chk("m2_cyc",   int'(c2), m_cyc[2]);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic drive(input bit r, input bit c, input logic [3:0] a, input logic [3:0] d, input bit k);
    reset = r; clear = c; axis = a; idle = d; inst = k;
  endtask

  typedef struct {
    bit         rst;
    bit         clr;
    logic [3:0] axis;
    logic [3:0] idle;
    bit         inst;
    bit         exp_block;
    logic [4:0] exp_src;
    int         exp_cyc;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, logic [3:0] a, logic [3:0] d, bit k,
                              bit eb, logic [4:0] es, int ec);
    vec_t v;
    v.rst = r; v.clr = c; v.axis = a; v.idle = d; v.inst = k;
    v.exp_block = eb; v.exp_src = es; v.exp_cyc = ec;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int seg;
    bit force_raw;

    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_blk[i] = 0; m_src[i] = 0; m_cyc[i] = 0;
    end

    // Reset state
    drive(1, 0, 4'b0110, 4'b0000, 1);
    step();
    step();
    chk("rst_block", int'(b0), 0);
    chk("rst_src",   int'(s0), 0);
    chk("rst_cyc",   int'(c0), 0);
    chk("rst_state", int'(dut0.state_q), 0);

    // Persistence at THRESH=16
    drive(0, 0, 4'b0010, 4'b0000, 0);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk("t1_pre_block", int'(b0), 0);
    end
    step();
    chk("t1_block", int'(b0), 1);
    chk("t1_src",   int'(s0), 5'b00010);
    chk("t1_cyc1",  int'(c0), 1);
    step();
    chk("t1_cyc2",  int'(c0), 2);
    step();
    chk("t1_cyc3",  int'(c0), 3);

    // One-cycle gap restarts the run
    drive(1, 0, 4'b0000, 4'b0000, 0);
    step();
    drive(0, 0, 4'b0010, 4'b0000, 0);
    for (int n = 0; n < 10; n++) begin
      step();
      chk("t2_burst1", int'(b0), 0);
    end
    drive(0, 0, 4'b0000, 4'b0000, 0);
    step();
    chk("t2_gap", int'(b0), 0);
    drive(0, 0, 4'b0010, 4'b0000, 0);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk("t2_burst2_pre", int'(b0), 0);
    end
    step();
    chk("t2_burst2_block", int'(b0), 1);

    // Idle-masked and unmasked channels never contribute
    drive(1, 0, 4'b0000, 4'b0000, 0);
    step();
    drive(0, 0, 4'b0101, 4'b0100, 0);
    for (int n = 0; n < 100; n++) begin
      step();
      chk("t3_block", int'(b0), 0);
    end
    chk("t3_state", int'(dut0.state_q), 0);

    // THRESH=1 non-sticky instance, table driven
    drive(1, 0, 4'b0000, 4'b0000, 0);
    step();
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'b10000, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'b10000, 2));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 5'b10000, 3));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 5'b10000, 3));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 5'b10000, 3));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0000, 0, 1, 5'b00010, 1));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0010, 0, 0, 5'b00010, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 0, 0, 5'b00010, 1));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 1, 1, 5'b10100, 1));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0000, 1, 1, 5'b10100, 2));
    tbl.push_back(mk(0, 1, 4'b0010, 4'b0000, 0, 0, 5'b00000, 0));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 0, 0, 5'b00000, 0));
    tbl.push_back(mk(0, 0, 4'b1000, 4'b0000, 0, 0, 5'b00000, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 5'b00000, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].axis, tbl[i].idle, tbl[i].inst);
      step();
      chk("t4_block", int'(b1), int'(tbl[i].exp_block));
      chk("t4_src",   int'(s1), int'(tbl[i].exp_src));
      chk("t4_cyc",   int'(c1), tbl[i].exp_cyc);
    end

    // Sticky CNT_W=4 THRESH=2: saturation, hold, clear
    drive(1, 0, 4'b0000, 4'b0000, 0);
    step();
    drive(0, 0, 4'b0010, 4'b0000, 0);
    step();
    chk("t5_first", int'(b2), 0);
    step();
    chk("t5_block", int'(b2), 1);
    chk("t5_cyc1",  int'(c2), 1);
    for (int n = 0; n < 38; n++) step();
    chk("t5_sat", int'(c2), 15);
    drive(0, 0, 4'b0000, 4'b0000, 0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t5_sticky", int'(b2), 1);
    end
    drive(0, 1, 4'b0000, 4'b0000, 0);
    step();
    chk("t5_clr_block", int'(b2), 0);
    chk("t5_clr_src",   int'(s2), 0);
    chk("t5_clr_cyc",   int'(c2), 0);

    // Reset during COUNT and during BLOCKED
    drive(0, 0, 4'b0010, 4'b0000, 0);
    for (int n = 0; n < 7; n++) step();
    chk("t6_cnt7",  int'(dut0.u_persist.count), 7);
    chk("t6_count", int'(dut0.state_q), 1);
    drive(1, 0, 4'b0010, 4'b0000, 0);
    step();
    chk("t6_rst_cnt",   int'(dut0.u_persist.count), 0);
    chk("t6_rst_state", int'(dut0.state_q), 0);
    drive(0, 0, 4'b0010, 4'b0000, 0);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk("t6_fresh_pre", int'(b0), 0);
    end
    step();
    chk("t6_fresh_block", int'(b0), 1);
    drive(1, 0, 4'b0010, 4'b0000, 0);
    step();
    chk("t6_rst2_block", int'(b0), 0);
    chk("t6_rst2_src",   int'(s0), 0);
    chk("t6_rst2_cyc",   int'(c0), 0);
    chk("t6_rst2_cnt",   int'(dut0.u_persist.count), 0);

    // Randomized bursts against the reference
    seg = 0;
    force_raw = 0;
    for (int n = 0; n < 1500; n++) begin
      if (seg == 0) begin
        seg = $urandom_range(1, 24);
        force_raw = ($urandom_range(0, 2) != 0);
      end
      seg--;
      reset = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 149) == 0);
      axis  = 4'($urandom);
      idle  = 4'($urandom) & 4'($urandom);
      inst  = ($urandom_range(0, 7) == 0);
      if (force_raw) begin
        if ($urandom_range(0, 1) == 1) begin
          inst = 1'b1;
        end else begin
          axis[2] = 1'b1;
          idle[2] = 1'b0;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
